// File: rtl/quiz_answer_timer.sv
// Quiz answer timer: round state machine, answer countdown, judging,
// saturating contestant scores and board LED drive.
module quiz_answer_timer #(
  parameter int TICK_DIV   = 50000000,
  parameter int ANSWER_SEC = 10,
  parameter int BLINK_DIV  = 12500000,
  parameter int SCORE_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic [3:0]             win,
  input  logic                   judge_ok,
  input  logic                   judge_bad,
  input  logic                   clr_scores,
  output logic [1:0]             state_o,
  output logic [1:0]             winner,
  output logic [3:0]             sec_left,
  output logic                   timeout,
  output logic [4*SCORE_W-1:0]   scores,
  output logic [3:0]             led
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [1:0]          r_winner, w_winner_next;
  logic [3:0]          r_sec, w_sec_next;
  logic                r_timeout, w_timeout_next;
  logic [TW-1:0]       r_tick_cnt, w_tick_next;
  logic [BW-1:0]       r_blink_cnt, w_blink_cnt_next;
  logic                r_blink, w_blink_next;
  logic [3:0]          r_led, w_led_next;
  logic                w_inc, w_dec;
  logic                w_tick_wrap, w_blink_wrap;
  logic [1:0]          w_win_idx;
  logic [SCORE_W-1:0]  r_score [4];

  assign w_tick_wrap  = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));

  // Multi-hot winner pulses resolve to the lowest contestant index
  always_comb begin
    w_win_idx = 2'd3;
    if (win[0])      w_win_idx = 2'd0;
    else if (win[1]) w_win_idx = 2'd1;
    else if (win[2]) w_win_idx = 2'd2;
  end

  // Next-state, countdown, blink and judging decisions
  always_comb begin
    w_state_next     = r_state;
    w_winner_next    = r_winner;
    w_sec_next       = r_sec;
    w_timeout_next   = 1'b0;
    w_tick_next      = '0;
    w_blink_cnt_next = '0;
    w_blink_next     = r_blink;
    w_inc            = 1'b0;
    w_dec            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_next = S_ARMED;
      end
      S_ARMED: begin
        if (win != 4'b0000) begin
          w_state_next  = S_ANSWER;
          w_winner_next = w_win_idx;
          w_sec_next    = 4'(ANSWER_SEC);
          w_blink_next  = 1'b1;
        end
      end
      S_ANSWER: begin
        w_tick_next      = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
        w_blink_cnt_next = w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
        w_blink_next     = w_blink_wrap ? ~r_blink : r_blink;
        // A judge freezes the window; it beats both the other judge and the tick
        if (judge_ok) begin
          w_inc        = 1'b1;
          w_state_next = S_RESULT;
        end else if (judge_bad) begin
          w_dec        = 1'b1;
          w_state_next = S_RESULT;
        end else if (w_tick_wrap && r_sec != 4'd0) begin
          w_sec_next = r_sec - 4'd1;
          if (r_sec == 4'd1) begin
            w_timeout_next = 1'b1;
            w_state_next   = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (arm) w_state_next = S_ARMED;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // LED pattern for the state being entered, so led is registered with it
  always_comb begin
    w_led_next = 4'b0000;
    case (w_state_next)
      S_ARMED:  w_led_next = 4'b1111;
      S_ANSWER: w_led_next = w_blink_next ? (4'b0001 << w_winner_next) : 4'b0000;
      S_RESULT: w_led_next = 4'b0001 << w_winner_next;
      default:  w_led_next = 4'b0000;
    endcase
  end

  // State, countdown and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_winner    <= 2'd0;
      r_sec       <= 4'd0;
      r_timeout   <= 1'b0;
      r_tick_cnt  <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_led       <= 4'b0000;
    end else begin
      r_state     <= w_state_next;
      r_winner    <= w_winner_next;
      r_sec       <= w_sec_next;
      r_timeout   <= w_timeout_next;
      r_tick_cnt  <= w_tick_next;
      r_blink_cnt <= w_blink_cnt_next;
      r_blink     <= w_blink_next;
      r_led       <= w_led_next;
    end
  end

  // Saturating scores; a clear overrides any same-cycle judge
  always_ff @(posedge clk) begin
    if (!rst_n || clr_scores) begin
      for (int i = 0; i < 4; i++) r_score[i] <= '0;
    end else if (w_inc && r_score[r_winner] != {SCORE_W{1'b1}}) begin
      r_score[r_winner] <= r_score[r_winner] + 1'b1;
    end else if (w_dec && r_score[r_winner] != '0) begin
      r_score[r_winner] <= r_score[r_winner] - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scores
      assign scores[gi*SCORE_W +: SCORE_W] = r_score[gi];
    end
  endgenerate

  assign state_o  = r_state;
  assign winner   = r_winner;
  assign sec_left = r_sec;
  assign timeout  = r_timeout;
  assign led      = r_led;

endmodule

// File: tb/tb_quiz_answer_timer.sv
// Randomized and directed bench for quiz_answer_timer against a round-level model.
module tb_quiz_answer_timer;

  localparam int TD = 10;
  localparam int AS = 3;
  localparam int BD = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic [3:0]    win = 4'b0;
  logic          judge_ok = 1'b0;
  logic          judge_bad = 1'b0;
  logic          clr_scores = 1'b0;
  logic [1:0]    state_o;
  logic [1:0]    winner;
  logic [3:0]    sec_left;
  logic          timeout;
  logic [4*SW-1:0] scores;
  logic [3:0]    led;

  quiz_answer_timer #(.TICK_DIV(TD), .ANSWER_SEC(AS), .BLINK_DIV(BD), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .win(win), .judge_ok(judge_ok),
    .judge_bad(judge_bad), .clr_scores(clr_scores), .state_o(state_o),
    .winner(winner), .sec_left(sec_left), .timeout(timeout), .scores(scores), .led(led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Round-level model: phase, winner, cycles spent answering, scores
  int m_state = 0;
  int m_win = 0;
  int m_sec = 0;
  int m_age = 0;
  bit m_to = 0;
  int m_sc[4] = '{0, 0, 0, 0};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_sec();
    if (m_state == 2) return AS - m_age / TD;
    return m_sec;
  endfunction

  function automatic int exp_led();
    case (m_state)
      1: return 15;
      2: return (((m_age / BD) % 2) == 0) ? (1 << m_win) : 0;
      3: return 1 << m_win;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(bit rn, bit a, logic [3:0] w, bit ok, bit bd, bit clr);
    bit j_ok, j_bad;
    j_ok = 0;
    j_bad = 0;
    if (!rn) begin
      m_state = 0; m_win = 0; m_sec = 0; m_age = 0; m_to = 0;
      for (int i = 0; i < 4; i++) m_sc[i] = 0;
      return;
    end
    m_to = 0;
    case (m_state)
      0: if (a) m_state = 1;
      1: if (w != 0) begin
           for (int i = 3; i >= 0; i--) if (w[i]) m_win = i;
           m_age = 0;
           m_state = 2;
         end
      2: begin
           if (ok) j_ok = 1;
           else if (bd) j_bad = 1;
           if (j_ok || j_bad) begin
             m_sec = AS - m_age / TD;
             m_state = 3;
           end else begin
             m_age++;
             if (m_age == AS * TD) begin
               m_to = 1;
               m_sec = 0;
               m_state = 3;
             end
           end
         end
      default: if (a) m_state = 1;
    endcase
    if (clr) begin
      for (int i = 0; i < 4; i++) m_sc[i] = 0;
    end else if (j_ok) begin
      if (m_sc[m_win] < (1 << SW) - 1) m_sc[m_win]++;
    end else if (j_bad) begin
      if (m_sc[m_win] > 0) m_sc[m_win]--;
    end
  endtask

  task automatic step(bit rn, bit a, logic [3:0] w, bit ok, bit bd, bit clr);
    @(negedge clk);
    rst_n = rn; arm = a; win = w; judge_ok = ok; judge_bad = bd; clr_scores = clr;
    @(posedge clk);
    model_edge(rn, a, w, ok, bd, clr);
    #1;
    chk("state", 32'(state_o), 32'(m_state));
    chk("winner", 32'(winner), 32'(m_win));
    chk("sec_left", 32'(sec_left), 32'(exp_sec()));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("led", 32'(led), 32'(exp_led()));
    for (int i = 0; i < 4; i++)
      chk($sformatf("score%0d", i), 32'(scores[i*SW +: SW]), 32'(m_sc[i]));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 4'b0, 0, 0, 0);
  endtask

  task automatic round_ok(logic [3:0] w);
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, w, 0, 0, 0);
    step(1, 0, 4'b0, 1, 0, 0);
  endtask

  int to_cnt, to_at;

  initial begin
    // Reset and ignored win in IDLE
    step(0, 0, 4'b0, 0, 0, 0);
    step(0, 0, 4'b0, 0, 0, 0);
    chk("rst_led", 32'(led), 32'd0);
    step(1, 0, 4'b0100, 0, 0, 0);
    chk("idle_win", 32'(state_o), 32'd0);
    $display("txn reset: state=%0d led=%b", state_o, led);

    // Basic round: win 0100, judge_ok five cycles later
    step(1, 1, 4'b0, 0, 0, 0);
    chk("armed", 32'(state_o), 32'd1);
    step(1, 0, 4'b0100, 0, 0, 0);
    chk("win_idx", 32'(winner), 32'd2);
    chk("win_sec", 32'(sec_left), 32'd3);
    idle(4);
    step(1, 0, 4'b0, 1, 0, 0);
    chk("ok_score2", 32'(scores[2*SW +: SW]), 32'd1);
    chk("ok_led", 32'(led), 32'b0100);
    idle(2);
    chk("ok_led_hold", 32'(led), 32'b0100);
    $display("txn round1: winner=%0d scores=%h", winner, scores);

    // Timeout round
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, 4'b0001, 0, 0, 0);
    to_cnt = 0; to_at = -1;
    for (int k = 1; k <= 35; k++) begin
      step(1, 0, 4'b0, 0, 0, 0);
      if (timeout) begin to_cnt++; to_at = k; end
      if (k == 10) chk("sec_after10", 32'(sec_left), 32'd2);
    end
    chk("to_cnt", 32'(to_cnt), 32'd1);
    chk("to_at", 32'(to_at), 32'd30);
    chk("to_state", 32'(state_o), 32'd3);
    $display("txn timeout: at=%0d sec_left=%0d", to_at, sec_left);

    // Multi-hot resolves to lowest index
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, 4'b1010, 0, 0, 0);
    chk("multihot", 32'(winner), 32'd1);
    step(1, 0, 4'b0, 1, 0, 0);
    $display("txn multihot: winner=%0d scores=%h", winner, scores);

    // Saturation for contestant 3, floor for contestant 0
    for (int r = 0; r < 16; r++) round_ok(4'b1000);
    chk("sat3", 32'(scores[3*SW +: SW]), 32'd15);
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, 4'b0001, 0, 0, 0);
    step(1, 0, 4'b0, 0, 1, 0);
    chk("floor0", 32'(scores[0 +: SW]), 32'd0);
    $display("txn saturation: scores=%h", scores);

    // Both judges together: +1 wins
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, 4'b0100, 0, 0, 0);
    step(1, 0, 4'b0, 1, 1, 0);
    chk("both_judge", 32'(scores[2*SW +: SW]), 32'd2);

    // judge_bad on the final tick: score drops, no timeout
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, 4'b0010, 0, 0, 0);
    idle(29);
    step(1, 0, 4'b0, 0, 1, 0);
    chk("final_bad_to", 32'(timeout), 32'd0);
    chk("final_bad_sc", 32'(scores[SW +: SW]), 32'd0);
    $display("txn final_tick_judge: timeout=%0d scores=%h", timeout, scores);

    // Clear beats a same-cycle judge
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, 4'b1000, 0, 0, 0);
    step(1, 0, 4'b0, 1, 0, 1);
    chk("clr_judge", 32'(scores), 32'd0);

    // Reset mid-answer with two seconds left
    round_ok(4'b0010);
    step(1, 1, 4'b0, 0, 0, 0);
    step(1, 0, 4'b0001, 0, 0, 0);
    idle(12);
    chk("mid_sec", 32'(sec_left), 32'd2);
    step(0, 0, 4'b0, 0, 0, 0);
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_sec", 32'(sec_left), 32'd0);
    chk("mid_rst_scores", 32'(scores), 32'd0);
    $display("txn mid_reset: state=%0d scores=%h", state_o, scores);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      bit rn, a, ok, bd, clr;
      logic [3:0] w;
      rn  = ($urandom_range(0, 499) != 0);
      a   = ($urandom_range(0, 7) == 0);
      w   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      ok  = ($urandom_range(0, 39) == 0);
      bd  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 59) == 0);
      step(rn, a, w, ok, bd, clr);
    end
    $display("txn random: scores=%h state=%0d", scores, state_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
